mem_port_arb: RTL and testbench

Two-requester arbiter that shares the single 32-bit external memory port between the instruction-cache tile fill engine and the data-cache tile fill/write-back engine. It sits between both cache tiles and the memory bus. It grants one requester at a time and holds the grant for a whole 4-DWORD tile burst. It also enforces a response timeout so a stalled transfer cannot hang either cache.

---
 rtl/mem_port_arb.sv | 173 +++++++++++++++++
 tb/tb_mem_port_arb.sv | 693 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arb.sv
// mem_port_arb
// Shares the single 32-bit external memory port between the I-cache tile fill
// engine and the D-cache tile fill/write-back engine. One requester owns the
// port at a time. With BURST_LOCK set, ownership is held for a whole 4-DWORD
// tile. A per-word response timeout keeps a stalled transfer from hanging
// either cache.
//
// Ports:
//   clock, reset                 system clock, synchronous active-high reset
//   icMemAddr/icMemOE            I-cache word address and read request
//   icMemData/icMemOK/icMemErr   I-cache read data, word done, word aborted
//   dcMemAddr/dcMemOE/dcMemWR    D-cache word address, read and write requests
//   dcMemOutData                 D-cache write data
//   dcMemData/dcMemOK/dcMemErr   D-cache read data, word done, word aborted
//   memAddr/memOE/memWR          memory address and strobes
//   memOutData/memInData         memory write and read data
//   memOK                        memory word complete
//   memBusy                      a grant is currently held
module mem_port_arb #(
    parameter int TIMEOUT    = 255,
    parameter bit BURST_LOCK = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] icMemAddr,
    input  logic        icMemOE,
    output logic [31:0] icMemData,
    output logic        icMemOK,
    output logic        icMemErr,
    input  logic [31:0] dcMemAddr,
    input  logic        dcMemOE,
    input  logic        dcMemWR,
    input  logic [31:0] dcMemOutData,
    output logic [31:0] dcMemData,
    output logic        dcMemOK,
    output logic        dcMemErr,
    output logic [31:0] memAddr,
    output logic        memOE,
    output logic        memWR,
    output logic [31:0] memOutData,
    input  logic [31:0] memInData,
    input  logic        memOK,
    output logic        memBusy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arbState_t;

    // Wait count at which a still-unanswered word is given up.
    localparam logic [7:0] TERM_COUNT = 8'(TIMEOUT - 1);

    arbState_t  state;
    arbState_t  nextState;
    logic       lastGnt;
    logic       nextLastGnt;
    logic [7:0] tWait;
    logic [7:0] nextTWait;
    logic       reqI;
    logic       reqD;
    logic       curReq;
    logic [1:0] curWordSel;
    logic       timeoutHit;

    assign reqI = icMemOE;
    assign reqD = dcMemOE | dcMemWR;

    // State register. lastGnt resets to the I side so that the D side wins
    // the very first tie after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            lastGnt <= 1'b0;
            tWait   <= 8'd0;
        end else begin
            state   <= nextState;
            lastGnt <= nextLastGnt;
            tWait   <= nextTWait;
        end
    end

    // Arbitration, port mux and word completion. In IDLE the port is parked
    // at zero and a late memOK is ignored. While granted, the owner's request
    // is forwarded combinationally so OK can return in the same cycle as
    // memOK. After the case, one common block decides how the granted word
    // ends. memOK beats a dropped request, and both beat the timeout, so a
    // memOK that lands on the terminal count still completes normally.
    always_comb begin
        nextState   = state;
        nextLastGnt = lastGnt;
        nextTWait   = tWait;
        curReq      = 1'b0;
        curWordSel  = 2'b00;
        timeoutHit  = 1'b0;
        memAddr     = 32'h0;
        memOE       = 1'b0;
        memWR       = 1'b0;
        memOutData  = 32'h0;
        icMemData   = 32'h0;
        icMemOK     = 1'b0;
        icMemErr    = 1'b0;
        dcMemData   = 32'h0;
        dcMemOK     = 1'b0;
        dcMemErr    = 1'b0;
        memBusy     = (state != IDLE);

        case (state)
            IDLE: begin
                nextTWait = 8'd0;
                if (reqI && reqD) begin
                    if (lastGnt) begin
                        nextState   = GNT_I;
                        nextLastGnt = 1'b0;
                    end else begin
                        nextState   = GNT_D;
                        nextLastGnt = 1'b1;
                    end
                end else if (reqD) begin
                    nextState   = GNT_D;
                    nextLastGnt = 1'b1;
                end else if (reqI) begin
                    nextState   = GNT_I;
                    nextLastGnt = 1'b0;
                end
            end
            GNT_I: begin
                memAddr    = icMemAddr;
                memOE      = icMemOE;
                icMemOK    = memOK;
                icMemData  = memOK ? memInData : 32'h0;
                curReq     = reqI;
                curWordSel = icMemAddr[3:2];
            end
            GNT_D: begin
                memAddr    = dcMemAddr;
                memOE      = dcMemOE;
                memWR      = dcMemWR;
                memOutData = dcMemOutData;
                dcMemOK    = memOK;
                dcMemData  = memOK ? memInData : 32'h0;
                curReq     = reqD;
                curWordSel = dcMemAddr[3:2];
            end
            default: begin
                nextState = IDLE;
            end
        endcase

        if (state != IDLE) begin
            if (memOK) begin
                nextTWait = 8'd0;
                if (!BURST_LOCK || (curWordSel == 2'b11)) begin
                    nextState = IDLE;
                end
            end else if (!curReq) begin
                nextState = IDLE;
                nextTWait = 8'd0;
            end else if (tWait == TERM_COUNT) begin
                timeoutHit = 1'b1;
                nextState  = IDLE;
                nextTWait  = 8'd0;
            end else begin
                nextTWait = tWait + 8'd1;
            end
        end

        icMemErr = timeoutHit && (state == GNT_I);
        dcMemErr = timeoutHit && (state == GNT_D);
    end

endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb
// Drives two arbiter instances from one shared set of inputs. instL uses
// TIMEOUT=4 with burst lock. instN uses TIMEOUT=6 without burst lock. Each
// instance is compared every cycle against an ownership model. Scenario tasks
// add checks taken directly from the expected behaviour: grant order, burst
// release, write data, timeout placement and reset behaviour.
module tb_mem_port_arb;

    localparam int TO_L = 4;
    localparam int TO_N = 6;

    typedef struct packed {
        logic [31:0] addr;
        logic        oe;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] icData;
        logic        icOk;
        logic        icErr;
        logic [31:0] dcData;
        logic        dcOk;
        logic        dcErr;
        logic        busy;
    } obs_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        wr;
    } dcWord_t;

    logic        clock;
    logic        reset;
    logic [31:0] icMemAddr;
    logic        icMemOE;
    logic [31:0] dcMemAddr;
    logic        dcMemOE;
    logic        dcMemWR;
    logic [31:0] dcMemOutData;
    logic [31:0] memInData;
    logic        memOK;

    logic [31:0] aIcMemData, aDcMemData, aMemAddr, aMemOutData;
    logic        aIcMemOK, aIcMemErr, aDcMemOK, aDcMemErr, aMemOE, aMemWR, aMemBusy;
    logic [31:0] bIcMemData, bDcMemData, bMemAddr, bMemOutData;
    logic        bIcMemOK, bIcMemErr, bDcMemOK, bDcMemErr, bMemOE, bMemWR, bMemBusy;

    obs_t obsA, obsB, eA, eB;

    int checks   = 0;
    int failures = 0;

    // Ownership model: 0 = nobody, 1 = I-cache, 2 = D-cache.
    int owner[2];
    int lastD[2];
    int waitCnt[2];

    logic [31:0] icQ[$];
    dcWord_t     dcQ[$];
    int          agentSel;
    int          memMode;

    mem_port_arb #(.TIMEOUT(TO_L), .BURST_LOCK(1'b1)) instL (
        .clock(clock), .reset(reset),
        .icMemAddr(icMemAddr), .icMemOE(icMemOE), .icMemData(aIcMemData),
        .icMemOK(aIcMemOK), .icMemErr(aIcMemErr),
        .dcMemAddr(dcMemAddr), .dcMemOE(dcMemOE), .dcMemWR(dcMemWR),
        .dcMemOutData(dcMemOutData), .dcMemData(aDcMemData),
        .dcMemOK(aDcMemOK), .dcMemErr(aDcMemErr),
        .memAddr(aMemAddr), .memOE(aMemOE), .memWR(aMemWR),
        .memOutData(aMemOutData), .memInData(memInData), .memOK(memOK),
        .memBusy(aMemBusy)
    );

    mem_port_arb #(.TIMEOUT(TO_N), .BURST_LOCK(1'b0)) instN (
        .clock(clock), .reset(reset),
        .icMemAddr(icMemAddr), .icMemOE(icMemOE), .icMemData(bIcMemData),
        .icMemOK(bIcMemOK), .icMemErr(bIcMemErr),
        .dcMemAddr(dcMemAddr), .dcMemOE(dcMemOE), .dcMemWR(dcMemWR),
        .dcMemOutData(dcMemOutData), .dcMemData(bDcMemData),
        .dcMemOK(bDcMemOK), .dcMemErr(bDcMemErr),
        .memAddr(bMemAddr), .memOE(bMemOE), .memWR(bMemWR),
        .memOutData(bMemOutData), .memInData(memInData), .memOK(memOK),
        .memBusy(bMemBusy)
    );

    assign obsA = {aMemAddr, aMemOE, aMemWR, aMemOutData, aIcMemData, aIcMemOK,
                   aIcMemErr, aDcMemData, aDcMemOK, aDcMemErr, aMemBusy};
    assign obsB = {bMemAddr, bMemOE, bMemWR, bMemOutData, bIcMemData, bIcMemOK,
                   bIcMemErr, bDcMemData, bDcMemOK, bDcMemErr, bMemBusy};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Outputs expected this cycle. The owner sees its own request on the
    // port, memOK completes its word at once, and an unanswered word that has
    // waited its full budget is aborted.
    function automatic obs_t expVec(input int k);
        obs_t e;
        int   lim;
        e   = '0;
        lim = (k == 0) ? TO_L : TO_N;
        if (owner[k] == 1) begin
            e.addr   = icMemAddr;
            e.oe     = icMemOE;
            e.busy   = 1'b1;
            e.icOk   = memOK;
            e.icData = memOK ? memInData : 32'h0;
            e.icErr  = !memOK && icMemOE && (waitCnt[k] == lim - 1);
        end else if (owner[k] == 2) begin
            e.addr   = dcMemAddr;
            e.oe     = dcMemOE;
            e.wr     = dcMemWR;
            e.wdata  = dcMemOutData;
            e.busy   = 1'b1;
            e.dcOk   = memOK;
            e.dcData = memOK ? memInData : 32'h0;
            e.dcErr  = !memOK && (dcMemOE || dcMemWR) && (waitCnt[k] == lim - 1);
        end
        return e;
    endfunction

    // Ownership after the coming edge. A tie goes to whoever did not own the
    // port last time. A word ends on memOK, on a dropped request, or when its
    // wait budget runs out.
    task automatic modelCommit();
        for (int k = 0; k < 2; k++) begin
            int          lim;
            bit          req;
            logic [31:0] a;
            lim = (k == 0) ? TO_L : TO_N;
            if (reset) begin
                owner[k]   = 0;
                lastD[k]   = 0;
                waitCnt[k] = 0;
            end else if (owner[k] == 0) begin
                waitCnt[k] = 0;
                if (icMemOE && (dcMemOE || dcMemWR)) owner[k] = (lastD[k] != 0) ? 1 : 2;
                else if (dcMemOE || dcMemWR)         owner[k] = 2;
                else if (icMemOE)                    owner[k] = 1;
                if (owner[k] != 0) lastD[k] = (owner[k] == 2) ? 1 : 0;
            end else begin
                req = (owner[k] == 1) ? icMemOE : (dcMemOE || dcMemWR);
                a   = (owner[k] == 1) ? icMemAddr : dcMemAddr;
                if (memOK) begin
                    waitCnt[k] = 0;
                    if ((k != 0) || (a[3:2] == 2'b11)) owner[k] = 0;
                end else if (!req) begin
                    owner[k]   = 0;
                    waitCnt[k] = 0;
                end else if (waitCnt[k] == lim - 1) begin
                    owner[k]   = 0;
                    waitCnt[k] = 0;
                end else begin
                    waitCnt[k] = waitCnt[k] + 1;
                end
            end
        end
    endtask

    // Requester agents and memory responder. They follow the selected
    // instance's expected outputs: a word leaves its queue on OK or Err, and
    // the memory answers one cycle after a strobe (mode 1), never (mode 0),
    // or randomly (mode 2).
    task automatic advance();
        obs_t eS;
        logic nextOk;
        eS = (agentSel == 0) ? eA : eB;
        if ((eS.icOk || eS.icErr) && (icQ.size() > 0)) void'(icQ.pop_front());
        if ((eS.dcOk || eS.dcErr) && (dcQ.size() > 0)) void'(dcQ.pop_front());
        case (memMode)
            0:       nextOk = 1'b0;
            1:       nextOk = (eS.oe || eS.wr) && !memOK;
            default: nextOk = ($urandom_range(0, 99) < 60);
        endcase
        modelCommit();
        @(posedge clock);
        #1;
        icMemOE   = (icQ.size() > 0);
        icMemAddr = 32'h0;
        if (icQ.size() > 0) icMemAddr = icQ[0];
        dcMemOE      = 1'b0;
        dcMemWR      = 1'b0;
        dcMemAddr    = 32'h0;
        dcMemOutData = 32'h0;
        if (dcQ.size() > 0) begin
            dcMemOE      = !dcQ[0].wr;
            dcMemWR      = dcQ[0].wr;
            dcMemAddr    = dcQ[0].addr;
            dcMemOutData = dcQ[0].data;
        end
        memOK     = nextOk;
        memInData = $urandom();
    endtask

    task automatic doReset();
        reset        = 1'b1;
        icQ.delete();
        dcQ.delete();
        icMemOE      = 1'b0;
        icMemAddr    = 32'h0;
        dcMemOE      = 1'b0;
        dcMemWR      = 1'b0;
        dcMemAddr    = 32'h0;
        dcMemOutData = 32'h0;
        memOK        = 1'b0;
        memInData    = 32'h0;
        eA           = '0;
        eB           = '0;
        advance();
        advance();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        memMode  = 0;
        agentSel = 0;
        doReset();
        reset   = 1'b1;
        icMemOE = 1'b1;
        dcMemOE = 1'b1;
        memOK   = 1'b1;
        @(negedge clock);
        eA = expVec(0);
        eB = expVec(1);
        checks += 2;
        if (obsA !== '0) begin
            failures++;
            $display("[TB] FAIL reset_held_L got=%h exp=0", obsA);
        end
        if (obsB !== '0) begin
            failures++;
            $display("[TB] FAIL reset_held_N got=%h exp=0", obsB);
        end
        advance();
        reset = 1'b0;
        @(negedge clock);
        eA = expVec(0);
        eB = expVec(1);
        checks += 2;
        if (obsA !== '0) begin
            failures++;
            $display("[TB] FAIL reset_idle_L got=%h exp=0", obsA);
        end
        if (obsB !== '0) begin
            failures++;
            $display("[TB] FAIL reset_idle_N got=%h exp=0", obsB);
        end
        advance();
    endtask

    task automatic test_icache_burst();
        int          okCount;
        int          lastOkCyc;
        logic [31:0] lastOkAddr;
        logic        busyLog[16];
        memMode  = 1;
        agentSel = 0;
        doReset();
        for (int w = 0; w < 4; w++) icQ.push_back(32'h1000 + 32'(4 * w));
        icMemOE    = 1'b1;
        icMemAddr  = 32'h1000;
        okCount    = 0;
        lastOkCyc  = 0;
        lastOkAddr = 32'h0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clock);
            eA = expVec(0);
            eB = expVec(1);
            checks += 2;
            if (obsA !== eA) begin
                failures++;
                $display("[TB] FAIL ic_burst_modelL cyc=%0d got=%h exp=%h", cyc, obsA, eA);
            end
            if (obsB !== eB) begin
                failures++;
                $display("[TB] FAIL ic_burst_modelN cyc=%0d got=%h exp=%h", cyc, obsB, eB);
            end
            busyLog[cyc] = aMemBusy;
            if (cyc == 1) begin
                checks++;
                if (aMemOE !== 1'b1 || aMemAddr !== 32'h1000) begin
                    failures++;
                    $display("[TB] FAIL ic_first_strobe oe=%b addr=%h exp oe=1 addr=00001000", aMemOE, aMemAddr);
                end
            end
            if (aIcMemOK === 1'b1) begin
                okCount++;
                lastOkCyc  = cyc;
                lastOkAddr = aMemAddr;
                checks++;
                if (aIcMemData !== memInData) begin
                    failures++;
                    $display("[TB] FAIL ic_read_data got=%h exp=%h", aIcMemData, memInData);
                end
            end
            advance();
        end
        checks += 3;
        if (okCount != 4) begin
            failures++;
            $display("[TB] FAIL ic_ok_count got=%0d exp=4", okCount);
        end
        if (lastOkAddr !== 32'h100C) begin
            failures++;
            $display("[TB] FAIL ic_last_addr got=%h exp=0000100c", lastOkAddr);
        end
        if (busyLog[lastOkCyc + 1] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ic_release busy=%b exp=0", busyLog[lastOkCyc + 1]);
        end
    endtask

    task automatic test_tie();
        int   seq[$];
        int   fourthCyc;
        logic busyLog[40];
        memMode  = 1;
        agentSel = 0;
        doReset();
        for (int w = 0; w < 4; w++) icQ.push_back(32'h3000 + 32'(4 * w));
        for (int w = 0; w < 8; w++) dcQ.push_back('{addr: 32'h4000 + 32'(4 * w), data: 32'h0, wr: 1'b0});
        icMemOE   = 1'b1;
        icMemAddr = 32'h3000;
        dcMemOE   = 1'b1;
        dcMemAddr = 32'h4000;
        fourthCyc = 0;
        for (int cyc = 0; cyc < 38; cyc++) begin
            @(negedge clock);
            eA = expVec(0);
            eB = expVec(1);
            checks += 2;
            if (obsA !== eA) begin
                failures++;
                $display("[TB] FAIL tie_modelL cyc=%0d got=%h exp=%h", cyc, obsA, eA);
            end
            if (obsB !== eB) begin
                failures++;
                $display("[TB] FAIL tie_modelN cyc=%0d got=%h exp=%h", cyc, obsB, eB);
            end
            busyLog[cyc] = aMemBusy;
            if (aDcMemOK === 1'b1) seq.push_back(2);
            if (aIcMemOK === 1'b1) seq.push_back(1);
            if (seq.size() == 4 && fourthCyc == 0) fourthCyc = cyc;
            advance();
        end
        checks += 2;
        if (seq.size() != 12) begin
            failures++;
            $display("[TB] FAIL tie_word_count got=%0d exp=12", seq.size());
        end
        if (busyLog[fourthCyc + 1] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL tie_idle_gap busy=%b exp=0", busyLog[fourthCyc + 1]);
        end
        for (int i = 0; i < 12 && i < seq.size(); i++) begin
            checks++;
            if (seq[i] != (((i < 4) || (i >= 8)) ? 2 : 1)) begin
                failures++;
                $display("[TB] FAIL tie_order idx=%0d got=%0d exp=%0d", i, seq[i], ((i < 4) || (i >= 8)) ? 2 : 1);
            end
        end
    endtask

    task automatic test_writeback();
        int n;
        int icOks;
        memMode  = 1;
        agentSel = 0;
        doReset();
        for (int w = 0; w < 4; w++)
            dcQ.push_back('{addr: 32'h2000 + 32'(4 * w), data: 32'hA5A50000 + 32'(w), wr: 1'b1});
        dcMemWR      = 1'b1;
        dcMemAddr    = 32'h2000;
        dcMemOutData = 32'hA5A50000;
        n     = 0;
        icOks = 0;
        for (int cyc = 0; cyc < 26; cyc++) begin
            @(negedge clock);
            eA = expVec(0);
            eB = expVec(1);
            checks += 2;
            if (obsA !== eA) begin
                failures++;
                $display("[TB] FAIL wb_modelL cyc=%0d got=%h exp=%h", cyc, obsA, eA);
            end
            if (obsB !== eB) begin
                failures++;
                $display("[TB] FAIL wb_modelN cyc=%0d got=%h exp=%h", cyc, obsB, eB);
            end
            if (aDcMemOK === 1'b1) begin
                checks++;
                if (aMemWR !== 1'b1 || aMemOutData !== 32'hA5A50000 + 32'(n) || aMemAddr !== 32'h2000 + 32'(4 * n)) begin
                    failures++;
                    $display("[TB] FAIL wb_word n=%0d wr=%b data=%h addr=%h exp wr=1 data=%h addr=%h",
                             n, aMemWR, aMemOutData, aMemAddr, 32'hA5A50000 + 32'(n), 32'h2000 + 32'(4 * n));
                end
                n++;
            end
            if (aIcMemOK === 1'b1) begin
                icOks++;
                checks++;
                if (n != 4) begin
                    failures++;
                    $display("[TB] FAIL wb_lockout d_words_done=%0d exp=4", n);
                end
            end
            advance();
            if (cyc == 3) for (int w = 0; w < 4; w++) icQ.push_back(32'h5000 + 32'(4 * w));
        end
        checks += 2;
        if (n != 4) begin
            failures++;
            $display("[TB] FAIL wb_count got=%0d exp=4", n);
        end
        if (icOks != 4) begin
            failures++;
            $display("[TB] FAIL wb_ic_after got=%0d exp=4", icOks);
        end
    endtask

    task automatic test_timeout();
        int grants;
        int errIdx;
        int errCyc;
        int errCount;
        int gExp;
        int okSeen;
        int errSeen;
        bit forced;
        memMode  = 0;
        agentSel = 0;
        doReset();
        icQ.push_back(32'h6000);
        icMemOE   = 1'b1;
        icMemAddr = 32'h6000;
        grants    = 0;
        errIdx    = -1;
        errCyc    = -10;
        errCount  = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clock);
            eA = expVec(0);
            eB = expVec(1);
            checks += 2;
            if (obsA !== eA) begin
                failures++;
                $display("[TB] FAIL tmo_modelL cyc=%0d got=%h exp=%h", cyc, obsA, eA);
            end
            if (obsB !== eB) begin
                failures++;
                $display("[TB] FAIL tmo_modelN cyc=%0d got=%h exp=%h", cyc, obsB, eB);
            end
            if (aMemBusy === 1'b1) grants++;
            if (aIcMemErr === 1'b1) begin
                errCount++;
                errIdx = grants;
                errCyc = cyc;
            end
            if (cyc == errCyc + 1) begin
                checks++;
                if (aMemOE !== 1'b0 || aMemBusy !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL tmo_release oe=%b busy=%b exp oe=0 busy=0", aMemOE, aMemBusy);
                end
            end
            advance();
        end
        checks += 2;
        if (errIdx != 4) begin
            failures++;
            $display("[TB] FAIL tmo_err_cycle got=%0d exp=4", errIdx);
        end
        if (errCount != 1) begin
            failures++;
            $display("[TB] FAIL tmo_err_count got=%0d exp=1", errCount);
        end

        // memOK arriving exactly on the terminal count completes the word.
        icQ.push_back(32'h601C);
        icMemOE   = 1'b1;
        icMemAddr = 32'h601C;
        gExp      = 0;
        okSeen    = 0;
        errSeen   = 0;
        forced    = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clock);
            eA = expVec(0);
            eB = expVec(1);
            checks += 2;
            if (obsA !== eA) begin
                failures++;
                $display("[TB] FAIL tmo_tie_modelL cyc=%0d got=%h exp=%h", cyc, obsA, eA);
            end
            if (obsB !== eB) begin
                failures++;
                $display("[TB] FAIL tmo_tie_modelN cyc=%0d got=%h exp=%h", cyc, obsB, eB);
            end
            if (aIcMemOK === 1'b1) okSeen++;
            if (aIcMemErr === 1'b1) errSeen++;
            if (eA.busy) gExp++;
            advance();
            if (gExp == 3 && !forced) begin
                memOK  = 1'b1;
                forced = 1'b1;
            end
        end
        checks += 2;
        if (okSeen != 1) begin
            failures++;
            $display("[TB] FAIL tmo_tie_ok got=%0d exp=1", okSeen);
        end
        if (errSeen != 0) begin
            failures++;
            $display("[TB] FAIL tmo_tie_err got=%0d exp=0", errSeen);
        end
    endtask

    task automatic test_reset_midburst();
        int okc;
        int errc;
        memMode  = 1;
        agentSel = 0;
        doReset();
        for (int w = 0; w < 4; w++) dcQ.push_back('{addr: 32'h7000 + 32'(4 * w), data: 32'h0, wr: 1'b0});
        dcMemOE   = 1'b1;
        dcMemAddr = 32'h7000;
        okc  = 0;
        errc = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clock);
            eA = expVec(0);
            eB = expVec(1);
            checks += 2;
            if (obsA !== eA) begin
                failures++;
                $display("[TB] FAIL rstmid_modelL cyc=%0d got=%h exp=%h", cyc, obsA, eA);
            end
            if (obsB !== eB) begin
                failures++;
                $display("[TB] FAIL rstmid_modelN cyc=%0d got=%h exp=%h", cyc, obsB, eB);
            end
            if (cyc == 4) begin
                checks += 2;
                if (obsA !== '0) begin
                    failures++;
                    $display("[TB] FAIL rstmid_outputs_L got=%h exp=0", obsA);
                end
                if (obsB !== '0) begin
                    failures++;
                    $display("[TB] FAIL rstmid_outputs_N got=%h exp=0", obsB);
                end
            end
            if (aDcMemOK === 1'b1) okc++;
            if (aDcMemErr === 1'b1) errc++;
            advance();
            reset = 1'b0;
            if (cyc == 2) begin
                reset = 1'b1;
                memOK = 1'b0;
                dcQ.delete();
            end
        end
        checks += 2;
        if (okc != 1) begin
            failures++;
            $display("[TB] FAIL rstmid_ok_count got=%0d exp=1", okc);
        end
        if (errc != 0) begin
            failures++;
            $display("[TB] FAIL rstmid_err_count got=%0d exp=0", errc);
        end
    endtask

    task automatic test_no_lock();
        int   seq[$];
        int   okCyc[$];
        logic busyLog[40];
        memMode  = 1;
        agentSel = 1;
        doReset();
        for (int w = 0; w < 4; w++) icQ.push_back(32'h9000 + 32'(4 * w));
        for (int w = 0; w < 4; w++) dcQ.push_back('{addr: 32'h8000 + 32'(4 * w), data: 32'h0, wr: 1'b0});
        icMemOE   = 1'b1;
        icMemAddr = 32'h9000;
        dcMemOE   = 1'b1;
        dcMemAddr = 32'h8000;
        for (int cyc = 0; cyc < 34; cyc++) begin
            @(negedge clock);
            eA = expVec(0);
            eB = expVec(1);
            checks += 2;
            if (obsA !== eA) begin
                failures++;
                $display("[TB] FAIL nolock_modelL cyc=%0d got=%h exp=%h", cyc, obsA, eA);
            end
            if (obsB !== eB) begin
                failures++;
                $display("[TB] FAIL nolock_modelN cyc=%0d got=%h exp=%h", cyc, obsB, eB);
            end
            busyLog[cyc] = bMemBusy;
            if (bDcMemOK === 1'b1) begin
                seq.push_back(2);
                okCyc.push_back(cyc);
            end
            if (bIcMemOK === 1'b1) begin
                seq.push_back(1);
                okCyc.push_back(cyc);
            end
            advance();
        end
        checks++;
        if (seq.size() != 8) begin
            failures++;
            $display("[TB] FAIL nolock_word_count got=%0d exp=8", seq.size());
        end
        for (int i = 0; i < 8 && i < seq.size(); i++) begin
            checks += 2;
            if (seq[i] != (((i % 2) == 0) ? 2 : 1)) begin
                failures++;
                $display("[TB] FAIL nolock_order idx=%0d got=%0d exp=%0d", i, seq[i], ((i % 2) == 0) ? 2 : 1);
            end
            if (busyLog[okCyc[i] + 1] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL nolock_idle_gap idx=%0d busy=%b exp=0", i, busyLog[okCyc[i] + 1]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] base;
        bit          wr;
        memMode = 2;
        for (int phase = 0; phase < 2; phase++) begin
            agentSel = phase;
            doReset();
            for (int cyc = 0; cyc < 300; cyc++) begin
                @(negedge clock);
                eA = expVec(0);
                eB = expVec(1);
                checks += 2;
                if (obsA !== eA) begin
                    failures++;
                    $display("[TB] FAIL random_modelL cyc=%0d got=%h exp=%h", cyc, obsA, eA);
                end
                if (obsB !== eB) begin
                    failures++;
                    $display("[TB] FAIL random_modelN cyc=%0d got=%h exp=%h", cyc, obsB, eB);
                end
                advance();
                reset = 1'b0;
                if ($urandom_range(0, 149) == 0) begin
                    reset = 1'b1;
                    icQ.delete();
                    dcQ.delete();
                end
                if (icQ.size() == 0 && $urandom_range(0, 3) == 0) begin
                    base = $urandom() & 32'hFFFF_FFF0;
                    for (int w = 0; w < 4; w++) icQ.push_back(base + 32'(4 * w));
                end
                if (dcQ.size() == 0 && $urandom_range(0, 3) == 0) begin
                    base = $urandom() & 32'hFFFF_FFF0;
                    wr   = ($urandom_range(0, 1) == 1);
                    for (int w = 0; w < 4; w++)
                        dcQ.push_back('{addr: base + 32'(4 * w), data: $urandom(), wr: wr});
                end
            end
        end
    endtask

    // Scenario sequence followed by the one-line summary.
    initial begin
        for (int k = 0; k < 2; k++) begin
            owner[k]   = 0;
            lastD[k]   = 0;
            waitCnt[k] = 0;
        end
        agentSel = 0;
        memMode  = 0;
        test_reset();
        test_icache_burst();
        test_tie();
        test_writeback();
        test_timeout();
        test_reset_midburst();
        test_no_lock();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
